// File: rtl/dac_sample_ctrl.sv
// rtl/dac_sample_ctrl.sv - PCM sample pacing, gain ramp and playback FSM for a sigma-delta DAC.
// Define DAC_SAMPLE_CTRL_SOFT_RAMP_EN for a soft gain ramp; otherwise gain jumps to target per tick.
module dac_sample_ctrl #(
  parameter int OSR       = 256,
  parameter int GAIN_STEP = 1
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        ENABLE,
  input  logic        MUTE,
  input  logic [15:0] S_DATA,
  input  logic        S_VALID,
  output logic        S_READY,
  output logic [15:0] SDM_INVAL,
  output logic        SDM_RESET,
  output logic [7:0]  UNDERRUN_CNT,
  output logic [1:0]  STATE
);

  localparam int              CW        = $clog2(OSR);
  localparam logic [CW-1:0]   TICK_AT   = CW'(OSR - 1);
  localparam logic [8:0]      GAIN_FULL = 9'd256;
`ifdef DAC_SAMPLE_CTRL_SOFT_RAMP_EN
  localparam logic [8:0]      GAIN_START = 9'd0;
`else
  localparam logic [8:0]      GAIN_START = GAIN_FULL;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CW-1:0]      r_cnt;
  logic [8:0]         r_gain;
  logic [8:0]         w_gain_nxt;
  logic [8:0]         w_gain_step;
  logic [8:0]         w_target;
  logic signed [15:0] r_hold;
  logic [15:0]        r_inval;
  logic               r_sdm_reset;
  logic [7:0]         r_underrun;
  logic               w_tick;
  logic               w_ready;
  logic               w_xfer;
  logic               w_underrun;
  logic signed [24:0] w_prod;

  assign w_tick   = ((r_state == ST_RUN) || (r_state == ST_DRAIN)) && (r_cnt == TICK_AT);
  assign w_target = ((r_state == ST_RUN) && !MUTE) ? GAIN_FULL : 9'd0;
  assign w_xfer   = w_ready && S_VALID;
  assign w_prod   = $signed({{9{r_hold[15]}}, r_hold}) * $signed({16'd0, r_gain});

`ifdef DAC_SAMPLE_CTRL_SOFT_RAMP_EN
  logic [9:0] w_up;
  assign w_up = {1'b0, r_gain} + 10'(GAIN_STEP);

  always_comb begin
    w_gain_step = w_target;
    if (w_target != 9'd0) begin
      w_gain_step = (w_up > 10'(GAIN_FULL)) ? GAIN_FULL : w_up[8:0];
    end else begin
      w_gain_step = (r_gain > 9'(GAIN_STEP)) ? (r_gain - 9'(GAIN_STEP)) : 9'd0;
    end
  end
`else
  assign w_gain_step = w_target;
`endif

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_gain_nxt  = r_gain;
    w_underrun  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (ENABLE) w_state_nxt = ST_PRIME;
      end
      ST_PRIME: begin
        w_ready = 1'b1;
        if (S_VALID) begin
          w_state_nxt = ST_RUN;
          w_gain_nxt  = GAIN_START;
        end else if (!ENABLE) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        w_ready = w_tick;
        if (w_tick) begin
          w_gain_nxt = w_gain_step;
          w_underrun = !S_VALID;
        end
        if (!ENABLE) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        // ENABLE is ignored here; drain always completes to IDLE.
        if (w_tick) begin
          w_gain_nxt = w_gain_step;
          if (w_gain_step == 9'd0) w_state_nxt = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_cnt       <= '0;
      r_gain      <= 9'd0;
      r_hold      <= 16'sd0;
      r_inval     <= 16'd0;
      r_sdm_reset <= 1'b1;
      r_underrun  <= 8'd0;
    end else begin
      if (((r_state == ST_RUN) || (r_state == ST_DRAIN)) && !w_tick) begin
        r_cnt <= r_cnt + CW'(1);
      end else begin
        r_cnt <= '0;
      end
      r_gain <= w_gain_nxt;
      if (w_xfer) r_hold <= $signed(S_DATA);
      if (w_underrun && (r_underrun != 8'hFF)) r_underrun <= r_underrun + 8'd1;
      r_inval     <= (w_state_nxt == ST_IDLE) ? 16'd0 : 16'(w_prod >>> 8);
      r_sdm_reset <= (w_state_nxt == ST_IDLE);
    end
  end

  assign S_READY      = w_ready;
  assign SDM_INVAL    = r_inval;
  assign SDM_RESET    = r_sdm_reset;
  assign UNDERRUN_CNT = r_underrun;
  assign STATE        = r_state;

endmodule

// File: tb/tb_dac_sample_ctrl.sv
// tb/tb_dac_sample_ctrl.sv - Self-checking bench for dac_sample_ctrl with a cycle-level reference model.
module tb_dac_sample_ctrl;

  localparam int OSR = 4;
  localparam int GS  = 64;
`ifdef DAC_SAMPLE_CTRL_SOFT_RAMP_EN
  localparam bit RAMP = 1'b1;
`else
  localparam bit RAMP = 1'b0;
`endif

  logic        CLK     = 1'b0;
  logic        RESET_N = 1'b0;
  logic        ENABLE  = 1'b0;
  logic        MUTE    = 1'b0;
  logic        S_VALID = 1'b0;
  logic [15:0] S_DATA  = 16'd0;
  logic        S_READY;
  logic [15:0] SDM_INVAL;
  logic        SDM_RESET;
  logic [7:0]  UNDERRUN_CNT;
  logic [1:0]  STATE;

  int d_n = 0, d_pass = 0, c_n = 0, c_pass = 0;
  bit cmp_en = 1'b0;

  dac_sample_ctrl #(.OSR(OSR), .GAIN_STEP(GS)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .ENABLE(ENABLE), .MUTE(MUTE),
    .S_DATA(S_DATA), .S_VALID(S_VALID), .S_READY(S_READY),
    .SDM_INVAL(SDM_INVAL), .SDM_RESET(SDM_RESET),
    .UNDERRUN_CNT(UNDERRUN_CNT), .STATE(STATE)
  );

  always #5 CLK = ~CLK;

  // Reference model: states 0..3, sample phase counter, gain 0..256, held sample.
  int          m_state, m_cnt, m_gain, m_hold, m_urun;
  logic [15:0] m_inval;
  bit          m_sdmrst;

  function automatic int step_gain(int g, int tgt);
    if (!RAMP) return tgt;
    if (g < tgt) return (g + GS > tgt) ? tgt : g + GS;
    return (g - GS < tgt) ? tgt : g - GS;
  endfunction

  function automatic bit m_ready();
    return (m_state == 1) || (m_state == 2 && m_cnt == OSR - 1);
  endfunction

  always @(posedge CLK or negedge RESET_N) begin : model
    int nst, ng, nh, nu;
    bit tick;
    if (!RESET_N) begin
      m_state <= 0; m_cnt <= 0; m_gain <= 0; m_hold <= 0; m_urun <= 0;
      m_inval <= 16'd0; m_sdmrst <= 1'b1;
    end else begin
      tick = (m_state >= 2) && (m_cnt == OSR - 1);
      nst = m_state; ng = m_gain; nh = m_hold; nu = m_urun;
      case (m_state)
        0: if (ENABLE) nst = 1;
        1: begin
          if (S_VALID) begin
            nh = int'($signed(S_DATA)); ng = RAMP ? 0 : 256; nst = 2;
          end else if (!ENABLE) nst = 0;
        end
        2: begin
          if (tick) begin
            if (S_VALID) nh = int'($signed(S_DATA));
            else nu = (m_urun < 255) ? m_urun + 1 : 255;
            ng = step_gain(m_gain, MUTE ? 0 : 256);
          end
          if (!ENABLE) nst = 3;
        end
        default: begin
          if (tick) begin
            ng = step_gain(m_gain, 0);
            if (ng == 0) nst = 0;
          end
        end
      endcase
      m_inval  <= (nst == 0) ? 16'd0 : 16'((m_hold * m_gain) >>> 8);
      m_sdmrst <= (nst == 0);
      m_cnt    <= (m_state >= 2 && !tick) ? m_cnt + 1 : 0;
      m_state  <= nst; m_gain <= ng; m_hold <= nh; m_urun <= nu;
    end
  end

  task automatic cchk(input string name, input int act, input int exp);
    c_n++;
    if (act == exp) c_pass++;
    else $display("FAIL model_%s t=%0t: got 0x%0h want 0x%0h", name, $time, act, exp);
  endtask

  always @(negedge CLK) begin
    if (cmp_en) begin
      cchk("STATE", int'(STATE), m_state);
      cchk("S_READY", int'(S_READY), int'(m_ready()));
      cchk("SDM_INVAL", int'(SDM_INVAL), int'(m_inval));
      cchk("SDM_RESET", int'(SDM_RESET), int'(m_sdmrst));
      cchk("UNDERRUN_CNT", int'(UNDERRUN_CNT), m_urun);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    d_n++;
    if (act == exp) d_pass++;
    else $display("FAIL %s t=%0t: got 0x%0h want 0x%0h", name, $time, act, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge CLK);
      #2;
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_state"}, int'(STATE), 0);
    chk({tag, "_s_ready"}, int'(S_READY), 0);
    chk({tag, "_inval"}, int'(SDM_INVAL), 0);
    chk({tag, "_sdm_reset"}, int'(SDM_RESET), 1);
    chk({tag, "_underrun"}, int'(UNDERRUN_CNT), 0);
  endtask

  initial begin
    int ones;
    int waited;
    cyc(3);
    cmp_en = 1'b1;
    chk_reset_values("rst");
    RESET_N = 1'b1;
    cyc(2);
    chk("idle_hold", int'(STATE), 0);

    ENABLE = 1'b1; S_VALID = 1'b1;
    S_DATA = RAMP ? 16'h7FFF : 16'h4000;
    cyc(1);
    chk("prime_state", int'(STATE), 1);
    chk("prime_ready", int'(S_READY), 1);
    chk("prime_sdm_reset", int'(SDM_RESET), 0);
    cyc(1);
    chk("run_state", int'(STATE), 2);
`ifdef DAC_SAMPLE_CTRL_SOFT_RAMP_EN
    cyc(1);
    chk("ramp_0", int'(SDM_INVAL), 'h0000);
    cyc(4); chk("ramp_1", int'(SDM_INVAL), 'h1FFF);
    cyc(4); chk("ramp_2", int'(SDM_INVAL), 'h3FFF);
    cyc(4); chk("ramp_3", int'(SDM_INVAL), 'h5FFF);
    cyc(4); chk("ramp_4", int'(SDM_INVAL), 'h7FFF);
`else
    S_DATA = 16'hC000;
    cyc(1); chk("first_sample", int'(SDM_INVAL), 'h4000);
    cyc(1); chk("ready_low", int'(S_READY), 0);
    cyc(1); chk("ready_tick", int'(S_READY), 1);
    cyc(2); chk("second_sample", int'(SDM_INVAL), 'hC000);
    ones = 0;
    repeat (8) begin
      @(negedge CLK);
      ones += int'(S_READY);
    end
    chk("ready_duty", ones, 2);
`endif

    S_DATA = 16'h2000; MUTE = 1'b1;
    cyc(24);
    chk("mute_inval", int'(SDM_INVAL), 0);
    chk("mute_state", int'(STATE), 2);
    chk("mute_underrun", int'(UNDERRUN_CNT), 0);
    MUTE = 1'b0;
    cyc(24);
    chk("unmute_inval", int'(SDM_INVAL), 'h2000);
    chk("unmute_state", int'(STATE), 2);
    chk("unmute_underrun", int'(UNDERRUN_CNT), 0);

    S_VALID = 1'b0;
    cyc(1210);
    chk("underrun_sat", int'(UNDERRUN_CNT), 255);
    chk("underrun_state", int'(STATE), 2);
    chk("underrun_frozen", int'(SDM_INVAL), 'h2000);

    S_VALID = 1'b1; ENABLE = 1'b0;
    cyc(1);
    chk("drain_state", int'(STATE), 3);
    chk("drain_ready", int'(S_READY), 0);
    ENABLE = 1'b1;
    waited = 0;
    while (STATE != 2'd0 && waited < 40) begin
      cyc(1);
      waited++;
    end
    chk("drain_done", int'(STATE), 0);
    chk("drain_sdm_reset", int'(SDM_RESET), 1);
    chk("drain_inval", int'(SDM_INVAL), 0);
    cyc(1);
    chk("reprime_state", int'(STATE), 1);
    chk("reprime_sdm_reset", int'(SDM_RESET), 0);

    cyc(1);
    cyc(5);
    #1 RESET_N = 1'b0;
    #1 chk_reset_values("async");
    ENABLE = 1'b0; S_VALID = 1'b0;
    cyc(2);
    RESET_N = 1'b1;
    cyc(3);
    chk("post_rst_idle", int'(STATE), 0);
    ENABLE = 1'b1;
    cyc(1);
    chk("post_rst_prime", int'(STATE), 1);

    @(negedge CLK);
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", d_pass + c_pass, d_n + c_n);
    $finish;
  end

endmodule
